// File: rtl/rx_frame_checker.sv
// rx_frame_checker: validates one received UART frame (data length mask,
// parity in even/odd/mark/space mode, stop bit) and emits a one-cycle
// result strobe with the masked data and parity/framing error flags.
// Optional macro RX_ERR_CNT_EN adds saturating parity/stop error counters
// with a synchronous clear input.
module rx_frame_checker #(
  parameter int DATA_WIDTH = 9,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start_Det,
  input  logic [3:0]            Data_Len,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  Deser_Done,
  input  logic [DATA_WIDTH-1:0] R_Data,
  input  logic                  Par_Valid,
  input  logic                  Parity_In,
  input  logic                  Stop_Valid,
  input  logic                  Stop_In,
`ifdef RX_ERR_CNT_EN
  input  logic                  Cnt_Clr,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt,
`endif
  output logic                  Frame_Valid,
  output logic [DATA_WIDTH-1:0] Frame_Data,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [1:0] {IDLE, WAIT_PAR, WAIT_STP, REPORT} state_t;

  state_t                state_reg, state_next;
  logic                  load_cfg, load_par, load_rep;
  logic [3:0]            len_eff;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] masked;
  logic                  exp_par_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  exp_par_reg;
  logic                  par_err_int;

  // A counter width below one bit cannot be built; this block only exists to
  // make that configuration visibly empty.
  if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
  end

  // Out-of-range lengths fall back to the full data width.
  assign len_eff = (Data_Len < 4'd5 || Data_Len > 4'(DATA_WIDTH)) ? 4'(DATA_WIDTH) : Data_Len;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
    assign mask[gi] = (4'(gi) < len_eff);
  end

  assign masked = R_Data & mask;

  // Expected parity bit for the frame currently being latched.
  always_comb begin
    exp_par_next = 1'b0;
    case (PAR_MODE)
      2'b00:   exp_par_next = ^masked;
      2'b01:   exp_par_next = ~(^masked);
      2'b10:   exp_par_next = 1'b1;
      default: exp_par_next = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and load strobes; Start_Det aborts everything but REPORT.
  always_comb begin
    state_next = state_reg;
    load_cfg   = 1'b0;
    load_par   = 1'b0;
    load_rep   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!Start_Det && Deser_Done) begin
          load_cfg   = 1'b1;
          state_next = PAR_EN ? WAIT_PAR : WAIT_STP;
        end
      end
      WAIT_PAR: begin
        if (Start_Det) begin
          state_next = IDLE;
        end else if (Par_Valid) begin
          load_par   = 1'b1;
          state_next = WAIT_STP;
        end
      end
      WAIT_STP: begin
        if (Start_Det) begin
          state_next = IDLE;
        end else if (Stop_Valid) begin
          load_rep   = 1'b1;
          state_next = REPORT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Frame_Valid = (state_reg == REPORT);

  // Frame datapath: latch data/parity on Deser_Done, update result on the stop bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_reg    <= '0;
      exp_par_reg <= 1'b0;
      par_err_int <= 1'b0;
      Frame_Data  <= '0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      if (load_cfg) begin
        data_reg    <= masked;
        exp_par_reg <= exp_par_next;
        par_err_int <= 1'b0;
      end
      if (load_par) begin
        par_err_int <= Parity_In ^ exp_par_reg;
      end
      if (load_rep) begin
        Frame_Data <= data_reg;
        par_err    <= par_err_int;
        stp_err    <= ~Stop_In;
      end else if (Start_Det) begin
        par_err <= 1'b0;
        stp_err <= 1'b0;
      end
    end
  end

`ifdef RX_ERR_CNT_EN
  // Saturating error counters, bumped once per reported frame; clear has priority.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (Cnt_Clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (state_reg == REPORT) begin
      if (par_err && !(&par_err_cnt)) par_err_cnt <= par_err_cnt + 1'b1;
      if (stp_err && !(&stp_err_cnt)) stp_err_cnt <= stp_err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_frame_checker.sv
// Randomised self-checking bench for rx_frame_checker. Expected results come
// from the frame rules (masked data, popcount parity, stop bit) per frame.
module tb_rx_frame_checker;

  localparam int DW    = 9;
  localparam int TB_CW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Start_Det, PAR_EN, Deser_Done, Par_Valid, Parity_In, Stop_Valid, Stop_In;
  logic [3:0]    Data_Len;
  logic [1:0]    PAR_MODE;
  logic [DW-1:0] R_Data;
  logic          Frame_Valid, par_err, stp_err;
  logic [DW-1:0] Frame_Data;
`ifdef RX_ERR_CNT_EN
  logic              Cnt_Clr;
  logic [TB_CW-1:0]  par_err_cnt, stp_err_cnt;
  int                pc_m, sc_m;
`endif

  int   total = 0;
  int   bad   = 0;
  bit   sd_in_report  = 0;
  bit   clr_in_report = 0;
  logic [DW-1:0] last_fd = '0;

  always #5 CLK = ~CLK;

  rx_frame_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(TB_CW)) dut (
    .CLK(CLK), .RST(RST), .Start_Det(Start_Det), .Data_Len(Data_Len),
    .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .Deser_Done(Deser_Done), .R_Data(R_Data),
    .Par_Valid(Par_Valid), .Parity_In(Parity_In), .Stop_Valid(Stop_Valid), .Stop_In(Stop_In),
`ifdef RX_ERR_CNT_EN
    .Cnt_Clr(Cnt_Clr), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt),
`endif
    .Frame_Valid(Frame_Valid), .Frame_Data(Frame_Data), .par_err(par_err), .stp_err(stp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      step();
      check("fv_gap", {31'd0, Frame_Valid}, 0);
    end
  endtask

  // One full frame; the expected result is derived from the frame rules.
  task automatic run_frame(input int len, input bit pe, input bit [1:0] mode,
                           input logic [DW-1:0] data, input bit pb, input bit sb,
                           input bit stray);
    int            leff;
    logic [DW-1:0] m;
    bit            ep, epe, ese;
    leff = (len < 5 || len > DW) ? DW : len;
    m    = data & DW'((1 << leff) - 1);
    case (mode)
      2'd0:    ep = ($countones(m) % 2) == 1;
      2'd1:    ep = ($countones(m) % 2) == 0;
      2'd2:    ep = 1;
      default: ep = 0;
    endcase
    epe = pe ? (pb != ep) : 0;
    ese = !sb;

    Data_Len = 4'(len); PAR_EN = pe; PAR_MODE = mode; R_Data = data; Deser_Done = 1;
    step();
    Deser_Done = 0;
    Data_Len = 4'($urandom); PAR_EN = 1'($urandom); PAR_MODE = 2'($urandom); R_Data = DW'($urandom);
    check("fv_early", {31'd0, Frame_Valid}, 0);
    gap();
    if (stray) begin
      if (pe) begin
        Deser_Done = 1; Stop_Valid = 1; Stop_In = 0;
        step();
        Deser_Done = 0; Stop_Valid = 0;
      end else begin
        Par_Valid = 1; Parity_In = 1;
        step();
        Par_Valid = 0;
      end
      check("fv_stray", {31'd0, Frame_Valid}, 0);
    end
    if (pe) begin
      Par_Valid = 1; Parity_In = pb;
      step();
      Par_Valid = 0;
      check("fv_par", {31'd0, Frame_Valid}, 0);
      gap();
    end
    Stop_Valid = 1; Stop_In = sb;
    step();
    Stop_Valid = 0;
    check("fv_report", {31'd0, Frame_Valid}, 1);
    check("fd_report", 32'(Frame_Data), 32'(m));
    check("par_err",   {31'd0, par_err}, {31'd0, epe});
    check("stp_err",   {31'd0, stp_err}, {31'd0, ese});
    $display("frame len=%0d pe=%0d mode=%0d data=%03h -> fd=%03h pe=%0d se=%0d",
             len, pe, mode, data, Frame_Data, par_err, stp_err);
    if (sd_in_report) Start_Det = 1;
`ifdef RX_ERR_CNT_EN
    if (clr_in_report) Cnt_Clr = 1;
`endif
    step();
    Start_Det = 0;
`ifdef RX_ERR_CNT_EN
    Cnt_Clr = 0;
    if (clr_in_report) begin
      pc_m = 0; sc_m = 0;
    end else begin
      if (epe && pc_m < (1 << TB_CW) - 1) pc_m++;
      if (ese && sc_m < (1 << TB_CW) - 1) sc_m++;
    end
    check("par_cnt", 32'(par_err_cnt), 32'(pc_m));
    check("stp_cnt", 32'(stp_err_cnt), 32'(sc_m));
`endif
    check("fv_after", {31'd0, Frame_Valid}, 0);
    check("fd_hold",  32'(Frame_Data), 32'(m));
    check("par_hold", {31'd0, par_err}, sd_in_report ? 0 : {31'd0, epe});
    check("stp_hold", {31'd0, stp_err}, sd_in_report ? 0 : {31'd0, ese});
    last_fd = m;
  endtask

  initial begin
    RST = 1; Start_Det = 0; Data_Len = 0; PAR_EN = 0; PAR_MODE = 0; Deser_Done = 0;
    R_Data = 0; Par_Valid = 0; Parity_In = 0; Stop_Valid = 0; Stop_In = 0;
`ifdef RX_ERR_CNT_EN
    Cnt_Clr = 0; pc_m = 0; sc_m = 0;
`endif
    step(); step();
    check("rst_fv", {31'd0, Frame_Valid}, 0);
    check("rst_fd", 32'(Frame_Data), 0);
    check("rst_pe", {31'd0, par_err}, 0);
    check("rst_se", {31'd0, stp_err}, 0);
    RST = 0;
    step();

    run_frame(8, 1, 2'd0, 9'h035, 0, 1, 0);
    run_frame(7, 1, 2'd1, 9'h1FF, 0, 1, 0);
    run_frame(7, 1, 2'd1, 9'h1FF, 1, 1, 0);
    run_frame(8, 1, 2'd2, 9'h0A5, 0, 0, 0);
    run_frame(8, 1, 2'd3, 9'h0A5, 0, 1, 0);
    run_frame(5, 0, 2'd0, 9'h01F, 0, 1, 1);
    run_frame(2, 1, 2'd0, 9'h1FF, 0, 1, 0);
    run_frame(15, 1, 2'd0, 9'h100, 1, 1, 0);

    // Start_Det in WAIT_PAR after a frame that left both flags set.
    run_frame(8, 1, 2'd2, 9'h011, 0, 0, 0);
    Data_Len = 8; PAR_EN = 1; PAR_MODE = 0; R_Data = 9'h0F0; Deser_Done = 1;
    step();
    Deser_Done = 0; Start_Det = 1;
    step();
    Start_Det = 0;
    check("sd_par_clr", {31'd0, par_err}, 0);
    check("sd_stp_clr", {31'd0, stp_err}, 0);
    Par_Valid = 1;  step(); Par_Valid = 0;
    Stop_Valid = 1; step(); Stop_Valid = 0;
    check("sd_no_fv", {31'd0, Frame_Valid}, 0);
    check("sd_fd_hold", 32'(Frame_Data), 32'(last_fd));

    // Start_Det together with Deser_Done: the frame never starts.
    Data_Len = 8; PAR_EN = 0; Deser_Done = 1; Start_Det = 1;
    step();
    Deser_Done = 0; Start_Det = 0;
    Stop_Valid = 1; Stop_In = 1; step(); Stop_Valid = 0;
    check("sd_dd_no_fv", {31'd0, Frame_Valid}, 0);

    // Start_Det during REPORT clears the flags afterwards.
    sd_in_report = 1;
    run_frame(6, 1, 2'd2, 9'h03C, 0, 0, 0);
    sd_in_report = 0;

    // Asynchronous reset while waiting for the stop bit.
    run_frame(9, 1, 2'd2, 9'h1AB, 0, 0, 0);
    Data_Len = 8; PAR_EN = 0; R_Data = 9'h055; Deser_Done = 1;
    step();
    Deser_Done = 0;
    RST = 1;
    #1;
    check("arst_fv", {31'd0, Frame_Valid}, 0);
    check("arst_fd", 32'(Frame_Data), 0);
    check("arst_pe", {31'd0, par_err}, 0);
    check("arst_se", {31'd0, stp_err}, 0);
`ifdef RX_ERR_CNT_EN
    pc_m = 0; sc_m = 0;
    check("arst_pc", 32'(par_err_cnt), 0);
`endif
    step();
    RST = 0;
    Stop_Valid = 1; Stop_In = 1; step(); Stop_Valid = 0;
    check("arst_no_fv", {31'd0, Frame_Valid}, 0);
    step();
    check("arst_no_fv2", {31'd0, Frame_Valid}, 0);

`ifdef RX_ERR_CNT_EN
    repeat (5) run_frame(8, 1, 2'd2, 9'h012, 0, 1, 0);
    check("pc_sat", 32'(par_err_cnt), 3);
    clr_in_report = 1;
    run_frame(8, 1, 2'd2, 9'h012, 0, 0, 0);
    clr_in_report = 0;
`endif

    for (int i = 0; i < 150; i++) begin
      sd_in_report  = ($urandom_range(0, 9) == 0);
`ifdef RX_ERR_CNT_EN
      clr_in_report = ($urandom_range(0, 9) == 0);
`endif
      run_frame(int'($urandom_range(0, 15)), 1'($urandom), 2'($urandom), DW'($urandom),
                1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
      gap();
    end
    sd_in_report  = 0;
    clr_in_report = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_checker.md
Name: rx_frame_checker

Overview:
Parametrised successor to the UART RX parity checker. Checks a complete received frame: masks data to the configured length, computes parity in one of four modes (or none), samples the stop bit, and issues a one-cycle frame-result strobe carrying data and parity/framing error flags. Sits between the deserializer/data-sampler and the RX output register, and is sequenced by the RX FSM.

Parameters:
DATA_WIDTH, 9, maximum data bits per frame; the runtime length must be 5..DATA_WIDTH.
CNT_WIDTH, 8, width of each error counter (only used with RX_ERR_CNT_EN).

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
Start_Det  in  1  start bit detected; aborts any frame in progress
Data_Len  in  4  data bits per frame (5..DATA_WIDTH); sampled on Deser_Done
PAR_EN  in  1  1 = parity bit present; sampled on Deser_Done
PAR_MODE  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0); sampled on Deser_Done
Deser_Done  in  1  one-cycle pulse: R_Data is valid
R_Data  in  DATA_WIDTH  received data, LSB first; bits >= Data_Len are ignored
Par_Valid  in  1  one-cycle pulse: Parity_In is valid
Parity_In  in  1  sampled parity bit
Stop_Valid  in  1  one-cycle pulse: Stop_In is valid
Stop_In  in  1  sampled stop bit (expected 1)
Frame_Valid  out  1  one-cycle strobe: frame result is valid
Frame_Data  out  DATA_WIDTH  masked data; bits >= Data_Len are forced to 0
par_err  out  1  parity mismatch for the reported frame
stp_err  out  1  stop bit was 0 for the reported frame

Behaviour:
- Reset (RST=1, async): state IDLE; Frame_Valid=0, Frame_Data=0, par_err=0, stp_err=0; internal expected parity and latched config cleared.
- Expected parity: even = XOR of the masked data; odd = XNOR of the masked data; mark = 1; space = 0. Registered on Deser_Done.
- FSM states and transitions:
  - IDLE: on Deser_Done, latch masked data, config and expected parity. Go to WAIT_PAR if PAR_EN=1, else WAIT_STP.
  - WAIT_PAR: on Par_Valid, par_err_int = Parity_In XOR expected; go to WAIT_STP.
  - WAIT_STP: on Stop_Valid, stp_err_int = ~Stop_In; go to REPORT.
  - REPORT: for one cycle, Frame_Valid=1 and Frame_Data/par_err/stp_err are driven; then go to IDLE.
- Frame_Valid latency: 1 cycle after the Stop_Valid cycle.
- par_err and stp_err hold their values until the next REPORT or Start_Det. Start_Det clears both to 0 on the next edge.
- Frame_Data holds its value until the next REPORT.
- When PAR_EN=0, par_err is always 0 for that frame.
- Start_Det in any state other than REPORT: return to IDLE, no Frame_Valid. Start_Det and Deser_Done in the same cycle: Start_Det wins.
- Start_Det during REPORT: the report completes (Frame_Valid=1), the next state is IDLE, and the flags clear on the following edge.
- Pulses that do not match the current state are ignored. Examples: Par_Valid in WAIT_STP, Deser_Done in WAIT_PAR, Par_Valid when PAR_EN=0.
- Data_Len outside 5..DATA_WIDTH: clamp to DATA_WIDTH.
- Config changes mid-frame have no effect until the next Deser_Done.

Optional Feature:
Macro RX_ERR_CNT_EN.
- Defined: adds output par_err_cnt [CNT_WIDTH], output stp_err_cnt [CNT_WIDTH] and input Cnt_Clr [1].
  - Each counter increments on a REPORT cycle whose corresponding error is 1.
  - Counters saturate at all-ones; no wrap-around.
  - Cnt_Clr zeroes both counters. Cnt_Clr in the same cycle as an increment: the clear wins.
  - Reset value of both counters is 0.
- Undefined: the counter ports and logic do not exist; all other behaviour is identical.

Test Plan:
1. Data_Len=8, even, R_Data=0x35 (4 ones), Parity_In=0, Stop_In=1 -> Frame_Valid 1 cycle after Stop_Valid, Frame_Data=0x35, par_err=0, stp_err=0.
2. Data_Len=7, odd, R_Data=0x1FF (DATA_WIDTH=9), Parity_In=0 -> Frame_Data=0x07F; expected parity=0 (7 ones); par_err=0. Repeat with Parity_In=1 -> par_err=1.
3. Mark mode, Parity_In=0, Stop_In=0 -> par_err=1, stp_err=1. Space mode, Parity_In=0 -> par_err=0.
4. PAR_EN=0, Data_Len=5, R_Data=0x1F, Stop_In=1; inject a stray Par_Valid -> Frame_Valid after Stop_Valid, par_err=0, and the stray pulse is ignored.
5. Start_Det asserted in WAIT_PAR; assert RST in WAIT_STP -> no Frame_Valid in either case; outputs at reset values immediately on RST.
6. With RX_ERR_CNT_EN, CNT_WIDTH=2: 5 parity-error frames -> par_err_cnt=3 (saturated); Cnt_Clr in the same cycle as a REPORT with an error -> both counters=0.
